// File: rtl/flash_arbiter.sv
// flash_arbiter: shares one flash_driver between port 0 (CPU reads) and port 1 (programmer read/write/erase).
// Latency: an open-session read acks READ_WAIT_CYCLES+1 cycles after grant; other ops follow the driver busy handshake.
// Backpressure: req/ack handshake; requests are held until ack and wait while the driver is owned. Busy watchdog: FLASH_ARB_TIMEOUT_EN.
module flash_arbiter #(
    parameter int FLASH_ADDR_SIZE  = 22,
    parameter int READ_WAIT_CYCLES = 2,
    parameter int TIMEOUT_CYCLES   = 65535
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       p0_req,
    input  logic [FLASH_ADDR_SIZE-1:0] p0_addr,
    output logic                       p0_ack,
    output logic [15:0]                p0_rdata,
    input  logic                       p1_req,
    input  logic [1:0]                 p1_op,
    input  logic [FLASH_ADDR_SIZE-1:0] p1_addr,
    input  logic [15:0]                p1_wdata,
    output logic                       p1_ack,
    output logic [15:0]                p1_rdata,
    output logic                       p1_err,
    output logic [FLASH_ADDR_SIZE-1:0] drv_addr,
    output logic [15:0]                drv_data_in,
    input  logic [15:0]                drv_data_out,
    output logic                       drv_enable_read,
    output logic                       drv_enable_write,
    output logic                       drv_enable_erase,
    input  logic                       drv_busy
);

    localparam logic [3:0] ST_RST_WAIT = 4'd0;
    localparam logic [3:0] ST_IDLE     = 4'd1;
    localparam logic [3:0] ST_RD_ISSUE = 4'd2;
    localparam logic [3:0] ST_RD_HI    = 4'd3;
    localparam logic [3:0] ST_RD_LO    = 4'd4;
    localparam logic [3:0] ST_SETTLE   = 4'd5;
    localparam logic [3:0] ST_DROP     = 4'd6;
    localparam logic [3:0] ST_WR_ISSUE = 4'd7;
    localparam logic [3:0] ST_WR_HI    = 4'd8;
    localparam logic [3:0] ST_WR_LO    = 4'd9;
    localparam logic [3:0] ST_DONE     = 4'd10;

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_ER = 2'b10;

    // Settle counter counts down to zero; an open session waits READ_WAIT_CYCLES, a fresh one waits 1.
    localparam int            SW          = $clog2(READ_WAIT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_OPEN = SW'(READ_WAIT_CYCLES - 1);

    logic [3:0]                 state_q, state_d;
    logic                       last_q, last_d;      // port served most recently
    logic                       owner_q, owner_d;    // port owning the current operation
    logic [1:0]                 op_q, op_d;
    logic [SW-1:0]              sc_q, sc_d;          // settle countdown
    logic                       dc_q, dc_d;          // second DROP cycle marker
    logic                       rw_q, rw_d;          // one idle-busy sample seen in RST_WAIT
    logic                       p0_ack_q, p0_ack_d;
    logic                       p1_ack_q, p1_ack_d;
    logic [15:0]                p0_rdata_q, p0_rdata_d;
    logic [15:0]                p1_rdata_q, p1_rdata_d;
    logic [FLASH_ADDR_SIZE-1:0] drv_addr_q, drv_addr_d;
    logic [15:0]                drv_data_in_q, drv_data_in_d;
    logic                       en_read_q, en_read_d;
    logic                       en_write_q, en_write_d;
    logic                       en_erase_q, en_erase_d;

    logic                       gnt_port;
    logic [1:0]                 gnt_op;
    logic [FLASH_ADDR_SIZE-1:0] gnt_addr;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int             TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
    logic                       p1_err_q, p1_err_d;
`endif

    // Round-robin pick: on a tie the port that was not served last wins.
    always_comb begin
        gnt_port = (p0_req && p1_req) ? ~last_q : p1_req;
        gnt_op   = gnt_port ? p1_op : OP_RD;
        gnt_addr = gnt_port ? p1_addr : p0_addr;
    end

    // Sequencer: arbitration, driver command protocol and ack/data return.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        owner_d       = owner_q;
        op_d          = op_q;
        sc_d          = sc_q;
        dc_d          = dc_q;
        rw_d          = rw_q;
        p0_ack_d      = 1'b0;
        p1_ack_d      = 1'b0;
        p0_rdata_d    = p0_rdata_q;
        p1_rdata_d    = p1_rdata_q;
        drv_addr_d    = drv_addr_q;
        drv_data_in_d = drv_data_in_q;
        en_read_d     = en_read_q;
        en_write_d    = 1'b0;
        en_erase_d    = 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        p1_err_d      = 1'b0;
`endif

        case (state_q)
            // The driver is not reset with us: wait for two consecutive idle samples.
            ST_RST_WAIT: begin
                if (drv_busy) begin
                    rw_d = 1'b0;
                end else if (rw_q) begin
                    rw_d    = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    rw_d = 1'b1;
                end
            end

            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    last_d  = gnt_port;
                    owner_d = gnt_port;
                    op_d    = gnt_op;
                    case (gnt_op)
                        OP_RD: begin
                            drv_addr_d = gnt_addr;
                            if (en_read_q) begin
                                sc_d    = SETTLE_OPEN;
                                state_d = ST_SETTLE;
                            end else begin
                                en_read_d = 1'b1;
                                state_d   = ST_RD_ISSUE;
                            end
                        end
                        OP_WR, OP_ER: begin
                            drv_addr_d = gnt_addr;
                            if (gnt_op == OP_WR) begin
                                drv_data_in_d = p1_wdata;
                            end
                            if (en_read_q) begin
                                // Let the driver fall back to idle before the new command.
                                en_read_d = 1'b0;
                                dc_d      = 1'b0;
                                state_d   = ST_DROP;
                            end else begin
                                en_write_d = (gnt_op == OP_WR);
                                en_erase_d = (gnt_op == OP_ER);
                                state_d    = ST_WR_ISSUE;
                            end
                        end
                        default: begin
                            // Reserved op: complete without touching the driver.
                            if (gnt_port) begin
                                p1_ack_d = 1'b1;
                            end else begin
                                p0_ack_d = 1'b1;
                            end
                            state_d = ST_DONE;
                        end
                    endcase
                end else begin
                    // Nothing pending: close the read session.
                    en_read_d = 1'b0;
                end
            end

            ST_RD_ISSUE: state_d = ST_RD_HI;

            ST_RD_HI: begin
                if (drv_busy) begin
                    state_d = ST_RD_LO;
                end
            end

            ST_RD_LO: begin
                if (!drv_busy) begin
                    sc_d    = '0;
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (sc_q == '0) begin
                    if (owner_q) begin
                        p1_rdata_d = drv_data_out;
                        p1_ack_d   = 1'b1;
                    end else begin
                        p0_rdata_d = drv_data_out;
                        p0_ack_d   = 1'b1;
                    end
                    state_d = ST_DONE;
                end else begin
                    sc_d = sc_q - SW'(1);
                end
            end

            ST_DROP: begin
                if (dc_q) begin
                    en_write_d = (op_q == OP_WR);
                    en_erase_d = (op_q == OP_ER);
                    state_d    = ST_WR_ISSUE;
                end else begin
                    dc_d = 1'b1;
                end
            end

            ST_WR_ISSUE: state_d = ST_WR_HI;

            ST_WR_HI: begin
                if (drv_busy) begin
                    state_d = ST_WR_LO;
                end
            end

            ST_WR_LO: begin
                if (!drv_busy) begin
                    if (owner_q) begin
                        p1_ack_d = 1'b1;
                    end else begin
                        p0_ack_d = 1'b1;
                    end
                    state_d = ST_DONE;
                end
            end

            // Ack cycle; a request still held is taken as new from the next cycle.
            ST_DONE: state_d = ST_IDLE;

            default: begin
                rw_d    = 1'b0;
                state_d = ST_RST_WAIT;
            end
        endcase

`ifdef FLASH_ARB_TIMEOUT_EN
        // Busy watchdog: abandon a stuck handshake and resynchronise with the driver.
        if (state_q == ST_RD_ISSUE || state_q == ST_WR_ISSUE) begin
            to_cnt_d = '0;
        end else if (state_q == ST_RD_HI || state_q == ST_RD_LO ||
                     state_q == ST_WR_HI || state_q == ST_WR_LO) begin
            if (to_cnt_q == TO_LIMIT) begin
                if (owner_q) begin
                    p1_ack_d = 1'b1;
                    p1_err_d = 1'b1;
                end else begin
                    p0_ack_d   = 1'b1;
                    p0_rdata_d = 16'hFFFF;
                end
                en_read_d = 1'b0;
                rw_d      = 1'b0;
                state_d   = ST_RST_WAIT;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RST_WAIT;
            last_q        <= 1'b1;
            owner_q       <= 1'b0;
            op_q          <= OP_RD;
            sc_q          <= '0;
            dc_q          <= 1'b0;
            rw_q          <= 1'b0;
            p0_ack_q      <= 1'b0;
            p1_ack_q      <= 1'b0;
            p0_rdata_q    <= '0;
            p1_rdata_q    <= '0;
            drv_addr_q    <= '0;
            drv_data_in_q <= '0;
            en_read_q     <= 1'b0;
            en_write_q    <= 1'b0;
            en_erase_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            owner_q       <= owner_d;
            op_q          <= op_d;
            sc_q          <= sc_d;
            dc_q          <= dc_d;
            rw_q          <= rw_d;
            p0_ack_q      <= p0_ack_d;
            p1_ack_q      <= p1_ack_d;
            p0_rdata_q    <= p0_rdata_d;
            p1_rdata_q    <= p1_rdata_d;
            drv_addr_q    <= drv_addr_d;
            drv_data_in_q <= drv_data_in_d;
            en_read_q     <= en_read_d;
            en_write_q    <= en_write_d;
            en_erase_q    <= en_erase_d;
        end
    end

`ifdef FLASH_ARB_TIMEOUT_EN
    // Watchdog counter and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            p1_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            p1_err_q <= p1_err_d;
        end
    end

    assign p1_err = p1_err_q;
`else
    assign p1_err = 1'b0;
`endif

    assign p0_ack           = p0_ack_q;
    assign p1_ack           = p1_ack_q;
    assign p0_rdata         = p0_rdata_q;
    assign p1_rdata         = p1_rdata_q;
    assign drv_addr         = drv_addr_q;
    assign drv_data_in      = drv_data_in_q;
    assign drv_enable_read  = en_read_q;
    assign drv_enable_write = en_write_q;
    assign drv_enable_erase = en_erase_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// tb_flash_arbiter: directed bench for flash_arbiter with a small flash_driver busy/data model.
// Latency: checks ack timing against hand-computed cycle counts.
// Backpressure: requesters hold req until ack; every wait is bounded.
`timescale 1ns/1ps
module tb_flash_arbiter;

    localparam int AW  = 22;
    localparam int RWC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req;
    logic [AW-1:0] p0_addr;
    logic          p0_ack;
    logic [15:0]   p0_rdata;
    logic          p1_req;
    logic [1:0]    p1_op;
    logic [AW-1:0] p1_addr;
    logic [15:0]   p1_wdata;
    logic          p1_ack;
    logic [15:0]   p1_rdata;
    logic          p1_err;
    logic [AW-1:0] drv_addr;
    logic [15:0]   drv_data_in;
    logic [15:0]   drv_data_out;
    logic          drv_enable_read;
    logic          drv_enable_write;
    logic          drv_enable_erase;
    logic          drv_busy = 1'b0;

    always #5 clk = ~clk;

    flash_arbiter #(
        .FLASH_ADDR_SIZE (AW),
        .READ_WAIT_CYCLES(RWC),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .p0_req          (p0_req),
        .p0_addr         (p0_addr),
        .p0_ack          (p0_ack),
        .p0_rdata        (p0_rdata),
        .p1_req          (p1_req),
        .p1_op           (p1_op),
        .p1_addr         (p1_addr),
        .p1_wdata        (p1_wdata),
        .p1_ack          (p1_ack),
        .p1_rdata        (p1_rdata),
        .p1_err          (p1_err),
        .drv_addr        (drv_addr),
        .drv_data_in     (drv_data_in),
        .drv_data_out    (drv_data_out),
        .drv_enable_read (drv_enable_read),
        .drv_enable_write(drv_enable_write),
        .drv_enable_erase(drv_enable_erase),
        .drv_busy        (drv_busy)
    );

    // Flash contents seen by the arbiter.
    function automatic logic [15:0] flash_word(input logic [AW-1:0] a);
        if (a == 22'h10) return 16'hBEEF;
        if (a == 22'h11) return 16'hCAFE;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    assign drv_data_out = flash_word(drv_addr);

    // Driver model: any new command makes busy high for 3 cycles; stuck_busy pins it high.
    logic stuck_busy = 1'b0;
    logic rd_prev    = 1'b0;
    int   bcnt       = 0;
    int   starts     = 0;
    always @(negedge clk) begin
        if ((drv_enable_read && !rd_prev) || drv_enable_write || drv_enable_erase) begin
            bcnt   = 3;
            starts = starts + 1;
        end
        rd_prev  = drv_enable_read;
        drv_busy = stuck_busy || (bcnt != 0);
        if (bcnt != 0) bcnt = bcnt - 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return p0_ack;
            1:       return p1_ack;
            2:       return drv_enable_write;
            3:       return drv_enable_erase;
            default: return p0_ack | p1_ack;
        endcase
    endfunction

    // Advance until the selected signal is high or the bound expires; n = ticks taken.
    task automatic wait_for(input string tag, input int which, input int bound, output int n);
        n = 0;
        while (!sel(which) && n < bound) begin
            tick();
            n++;
        end
        check_eq({tag, " seen"}, 32'(sel(which)), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        int t_drop;
        int t_wr;
        int wr_pulses;
        int viol;
        int seq[$];

        rst_n = 1'b0; p0_req = 1'b0; p0_addr = '0;
        p1_req = 1'b0; p1_op = 2'b00; p1_addr = '0; p1_wdata = '0;
        tick(); tick();
        check_eq("rst p0_ack",     32'(p0_ack), 0);
        check_eq("rst p1_ack",     32'(p1_ack), 0);
        check_eq("rst p1_err",     32'(p1_err), 0);
        check_eq("rst enable_read", 32'(drv_enable_read), 0);
        check_eq("rst drv_addr",   32'(drv_addr), 0);
        check_eq("rst p0_rdata",   32'(p0_rdata), 0);
        rst_n = 1'b1;

        // Fresh read with busy handshake, then open-session read of the next word.
        p0_addr = 22'h10; p0_req = 1'b1;
        wait_for("t1 p0_ack", 0, 60, n);
        check_eq("t1 p0_rdata", 32'(p0_rdata), 32'hBEEF);
        check_eq("t1 p1 quiet", 32'(p1_ack), 0);
        check_eq("t1 session open", 32'(drv_enable_read), 1);
        s0 = starts;
        p0_addr = 22'h11;
        tick();
        check_eq("t1 ack one cycle", 32'(p0_ack), 0);
        check_eq("t1 rdata held", 32'(p0_rdata), 32'hBEEF);
        wait_for("t2 p0_ack", 0, 20, n);
        check_eq("t2 ack spacing", 32'(n + 1), 32'(RWC + 2));
        check_eq("t2 drv_addr", 32'(drv_addr), 32'h11);
        check_eq("t2 p0_rdata", 32'(p0_rdata), 32'hCAFE);
        check_eq("t2 no busy handshake", 32'(starts - s0), 0);
        check_eq("t2 session held", 32'(drv_enable_read), 1);
        p0_req = 1'b0;
        tick();
        check_eq("close +1", 32'(drv_enable_read), 1);
        tick();
        check_eq("close +2", 32'(drv_enable_read), 0);

        // Simultaneous requests after reset: p0 first, then p1 write with DROP.
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        p0_addr = 22'h20; p0_req = 1'b1;
        p1_op = 2'b01; p1_addr = 22'h200; p1_wdata = 16'h1234; p1_req = 1'b1;
        wait_for("t3 first ack", 4, 60, n);
        check_eq("t3 p0 first", 32'(p0_ack), 1);
        check_eq("t3 p1 not first", 32'(p1_ack), 0);
        check_eq("t3 p0_rdata", 32'(p0_rdata), 32'h5A7A);
        p0_req = 1'b0;
        n = 0; t_drop = -1; t_wr = -1; wr_pulses = 0;
        while (!p1_ack && n < 40) begin
            tick();
            n++;
            if (!drv_enable_read && t_drop < 0) t_drop = n;
            if (drv_enable_write) begin
                wr_pulses++;
                if (t_wr < 0) begin
                    t_wr = n;
                    check_eq("t3 wr data", 32'(drv_data_in), 32'h1234);
                    check_eq("t3 wr addr", 32'(drv_addr), 32'h200);
                end
            end
        end
        check_eq("t3 p1_ack seen", 32'(p1_ack), 1);
        check_eq("t3 drop cycles", 32'(t_wr - t_drop), 2);
        check_eq("t3 write pulses", 32'(wr_pulses), 1);
        check_eq("t3 ack after pulse", 32'(n - t_wr), 4);
        check_eq("t3 busy low at ack", 32'(drv_busy), 0);
        check_eq("t3 p1_err", 32'(p1_err), 0);
        p1_req = 1'b0;

        // Both ports hold requests: grants alternate starting with p0.
        p0_addr = 22'h20; p1_op = 2'b00; p1_addr = 22'h300;
        p0_req = 1'b1; p1_req = 1'b1;
        n = 0;
        while (seq.size() < 8 && n < 400) begin
            tick();
            n++;
            if (p0_ack) seq.push_back(0);
            if (p1_ack) seq.push_back(1);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        check_eq("t4 ack count", 32'(seq.size()), 8);
        foreach (seq[i]) check_eq($sformatf("t4 grant %0d", i), 32'(seq[i]), 32'(i % 2));
        check_eq("t4 p1_rdata", 32'(p1_rdata), 32'h595A);
        tick(); tick(); tick();

        // Reserved op: ack one cycle after grant, no driver activity.
        s0 = starts;
        p1_op = 2'b11; p1_addr = 22'h555; p1_req = 1'b1;
        wait_for("rsv p1_ack", 1, 10, n);
        check_eq("rsv latency", 32'(n), 1);
        check_eq("rsv rdata kept", 32'(p1_rdata), 32'h595A);
        check_eq("rsv drv_addr kept", 32'(drv_addr), 32'h300);
        check_eq("rsv no command", 32'(starts - s0), 0);
        p1_req = 1'b0;
        tick(); tick();

        // Erase interrupted by reset while the driver is busy; reissued afterwards.
        p1_op = 2'b10; p1_addr = 22'h400; p1_req = 1'b1;
        wait_for("t5 erase", 3, 40, n);
        tick();
        check_eq("t5 busy before reset", 32'(drv_busy), 1);
        stuck_busy = 1'b1;
        rst_n = 1'b0;
        #1;
        check_eq("t5 rst drv_addr", 32'(drv_addr), 0);
        check_eq("t5 rst p0_rdata", 32'(p0_rdata), 0);
        check_eq("t5 rst p1_rdata", 32'(p1_rdata), 0);
        check_eq("t5 rst p1_ack", 32'(p1_ack), 0);
        tick(); tick();
        rst_n = 1'b1;
        viol = 0;
        repeat (6) begin
            tick();
            if (drv_enable_erase || drv_enable_write || drv_enable_read || p1_ack) viol++;
        end
        check_eq("t5 quiet while busy", 32'(viol), 0);
        stuck_busy = 1'b0;
        wait_for("t5 reissue", 3, 20, n);
        check_eq("t5 reissue delay", 32'(n), 3);
        check_eq("t5 reissue addr", 32'(drv_addr), 32'h400);
        wait_for("t5 p1_ack", 1, 20, n);
        p1_req = 1'b0;
        tick(); tick(); tick();

`ifdef FLASH_ARB_TIMEOUT_EN
        // Busy stuck high on a write: watchdog acks with error after 16 wait cycles.
        stuck_busy = 1'b1;
        p1_op = 2'b01; p1_addr = 22'h40; p1_wdata = 16'h5555; p1_req = 1'b1;
        wait_for("to write", 2, 20, n);
        wait_for("to p1_ack", 1, 40, n);
        check_eq("to latency", 32'(n), 17);
        check_eq("to p1_err", 32'(p1_err), 1);
        check_eq("to session closed", 32'(drv_enable_read), 0);
        p1_req = 1'b0;
        stuck_busy = 1'b0;
        tick(); tick(); tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
